// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the RiSC-16 data-memory access path.
package risc16_mem_pkg;

  localparam int DATA_W = 16;
  localparam int IMM7_W = 7;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    LOAD,
    RESP
  } state_e;

  function automatic logic [DATA_W-1:0] sext7(input logic [IMM7_W-1:0] imm);
    return {{(DATA_W-IMM7_W){imm[IMM7_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, data-memory and writeback signals of the memory access unit.
interface mem_access_unit_if #(
  parameter int DATA_W = 16
);

  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [DATA_W-1:0] req_base;
  logic [6:0]        req_imm7;
  logic [DATA_W-1:0] req_data;
  logic [2:0]        req_rd;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_sw;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [2:0]        rsp_rd;
  logic              busy;

  // master is the access unit itself; slave is the pipeline/memory around it
  modport master (
    input  req_valid, req_is_store, req_base, req_imm7, req_data, req_rd,
    input  mem_rdata, rsp_ready,
    output req_ready, busy, mem_addr, mem_sw, mem_wdata,
    output rsp_valid, rsp_data, rsp_rd
  );

  modport slave (
    output req_valid, req_is_store, req_base, req_imm7, req_data, req_rd,
    output mem_rdata, rsp_ready,
    input  req_ready, busy, mem_addr, mem_sw, mem_wdata,
    input  rsp_valid, rsp_data, rsp_rd
  );

endinterface

// File: rtl/mem_access_unit_agu.sv
// Address generation: regB plus sign-extended 7-bit offset, wrapping at DATA_W bits.
module risc16_agu #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] base,
  input  logic [6:0]        imm7,
  output logic [DATA_W-1:0] ea
);

  import risc16_mem_pkg::*;

  assign ea = base + {{(DATA_W-IMM7_W){imm7[IMM7_W-1]}}, imm7};

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the RiSC-16 data-memory port: LW/SW sequencing with a
// configurable read latency and a valid/ready load-response channel.
module mem_access_unit #(
  parameter int DATA_W     = risc16_mem_pkg::DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.master bus
);

  import risc16_mem_pkg::*;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              mem_sw_q, mem_sw_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [2:0]        rsp_rd_q, rsp_rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] ea;

  risc16_agu #(.DATA_W(DATA_W)) u_agu (
    .base (bus.req_base),
    .imm7 (bus.req_imm7),
    .ea   (ea)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_data_q  <= '0;
      mem_sw_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_data_q  <= rsp_data_d;
      mem_sw_q    <= mem_sw_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rd_q    <= rsp_rd_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_data_d  = rsp_data_q;
    mem_sw_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rd_d    = rsp_rd_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          mem_addr_d  = ea;
          mem_wdata_d = bus.req_data;
          rsp_rd_d    = bus.req_rd;
          if (bus.req_is_store) begin
            mem_sw_d = 1'b1;
            state_d  = STORE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = LOAD;
          end
        end
      end
      STORE: begin
        state_d = IDLE;
      end
      LOAD: begin
        // rdata is only trusted in the cycle the countdown reaches zero
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_data_d  = bus.mem_rdata;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_sw    = mem_sw_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_rd    = rsp_rd_q;

endmodule
